// File: rtl/event_encoder_8to3.sv
// -----------------------------------------------------------------------------
// event_encoder_8to3
//
// Registered 8-to-3 event encoder. Rising edges on the request lines are
// latched as pending events. The highest-index pending event is presented as a
// binary code through a valid/ready handshake, one code per cycle at most.
//
// Ports:
//   clk       in   1     system clock, rising-edge active
//   rst       in   1     synchronous active-high reset
//   en        in   1     enable for edge capture (draining continues when 0)
//   d         in   N     request lines, assumed synchronous to clk
//   ready     in   1     consumer accepts the presented code this cycle
//   ovf_clr   in   1     clears the sticky overflow flag
//   code      out  CW    encoded index of the presented event
//   valid     out  1     code is valid
//   pend      out  N     pending event vector (registered)
//   pend_cnt  out  CW+1  popcount of pend (registered)
//   overflow  out  1     sticky: an edge arrived on an already-pending line
// -----------------------------------------------------------------------------
module event_encoder_8to3 #(
    parameter int N  = 8,   // must equal 2**CW
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  d,
    input  logic          ready,
    input  logic          ovf_clr,
    output logic [CW-1:0] code,
    output logic          valid,
    output logic [N-1:0]  pend,
    output logic [CW:0]   pend_cnt,
    output logic          overflow
);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t         state;
    logic [N-1:0]   d_q;

    logic [N-1:0]   edge_det;
    logic [CW-1:0]  hi_idx;
    logic           load;
    logic [N-1:0]   take;
    logic [N-1:0]   pend_next;
    logic [CW:0]    cnt_next;
    logic           ovf_set;

    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves a variable unassigned and no latch is built.
    always_comb begin
        edge_det = en ? (d & ~d_q) : '0;

        // Ascending scan: the last set bit seen is the highest index.
        hi_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) hi_idx = CW'(i);
        end

        // A new code is loaded from IDLE, or from SHOW when the current one is
        // accepted; either way only if something is pending.
        load = (pend != '0) && ((state == IDLE) || ready);

        take = '0;
        if (load) take[hi_idx] = 1'b1;

        // An edge on the bit being taken this cycle is a fresh event and stays.
        pend_next = (pend & ~take) | edge_det;

        cnt_next = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next = cnt_next + {{CW{1'b0}}, pend_next[i]};
        end

        ovf_set = |(edge_det & pend & ~take);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            d_q      <= '0;
            pend     <= '0;
            pend_cnt <= '0;
            code     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            d_q      <= d;
            pend     <= pend_next;
            pend_cnt <= cnt_next;

            // Set has priority over a simultaneous clear.
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;

            case (state)
                IDLE: begin
                    if (load) begin
                        code  <= hi_idx;
                        valid <= 1'b1;
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    if (ready) begin
                        if (load) begin
                            code <= hi_idx;     // back-to-back, no bubble
                        end else begin
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_encoder_8to3.sv
// -----------------------------------------------------------------------------
// tb_event_encoder_8to3
//
// Directed testbench for event_encoder_8to3. Inputs change 1 time unit after
// each rising edge; outputs are sampled at that same point, well away from
// the next active edge.
// -----------------------------------------------------------------------------
module tb_event_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic       ready;
    logic       ovf_clr;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pend;
    logic [3:0] pend_cnt;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    event_encoder_8to3 dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .d        (d),
        .ready    (ready),
        .ovf_clr  (ovf_clr),
        .code     (code),
        .valid    (valid),
        .pend     (pend),
        .pend_cnt (pend_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; d = 8'h00; ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_code", 32'(code), 32'h0);
        check("rst_pend", 32'(pend), 32'h00);
        check("rst_cnt", 32'(pend_cnt), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);

        // ---- single pulse on d[5] ----
        rst = 1'b0;
        tick();
        d = 8'h20;
        tick();
        check("p5_pend", 32'(pend), 32'h20);
        check("p5_valid_early", 32'(valid), 32'h0);
        d = 8'h00;
        tick();
        check("p5_valid", 32'(valid), 32'h1);
        check("p5_code", 32'(code), 32'h5);
        check("p5_pend_taken", 32'(pend), 32'h00);
        ready = 1'b1;
        tick();
        check("p5_done_valid", 32'(valid), 32'h0);
        check("p5_done_pend", 32'(pend), 32'h00);
        ready = 1'b0;

        // ---- three simultaneous events, priority drain ----
        d = 8'h4A;
        tick();
        check("m_pend", 32'(pend), 32'h4A);
        check("m_cnt", 32'(pend_cnt), 32'h3);
        d = 8'h00;
        tick();
        check("m_code6", 32'(code), 32'h6);
        check("m_valid6", 32'(valid), 32'h1);
        check("m_cnt2", 32'(pend_cnt), 32'h2);
        tick();
        check("m_hold6", 32'(code), 32'h6);
        ready = 1'b1;
        tick();
        check("m_code3", 32'(code), 32'h3);
        check("m_valid3", 32'(valid), 32'h1);
        tick();
        check("m_code1", 32'(code), 32'h1);
        check("m_valid1", 32'(valid), 32'h1);
        check("m_pend0", 32'(pend), 32'h00);
        tick();
        check("m_valid_off", 32'(valid), 32'h0);
        ready = 1'b0;

        // ---- overflow on repeated index while presented ----
        d = 8'h20; tick();
        d = 8'h00; tick();
        check("o_code5", 32'(code), 32'h5);
        d = 8'h20; tick();
        check("o_requeue_pend", 32'(pend), 32'h20);
        check("o_requeue_ovf", 32'(overflow), 32'h0);
        d = 8'h00; tick();
        d = 8'h20; tick();
        check("o_set", 32'(overflow), 32'h1);
        d = 8'h00; tick();
        check("o_sticky", 32'(overflow), 32'h1);
        check("o_code_stable", 32'(code), 32'h5);
        d = 8'h20; ovf_clr = 1'b1; tick();
        check("o_set_wins", 32'(overflow), 32'h1);
        d = 8'h00; tick();
        check("o_cleared", 32'(overflow), 32'h0);
        ovf_clr = 1'b0;
        ready = 1'b1; tick();
        check("o_drain_code", 32'(code), 32'h5);
        check("o_drain_valid", 32'(valid), 32'h1);
        tick();
        check("o_drain_done", 32'(valid), 32'h0);
        check("o_drain_pend", 32'(pend), 32'h00);
        ready = 1'b0;

        // ---- enable gating ----
        en = 1'b0; d = 8'h04; tick();
        check("e_blocked_pend", 32'(pend), 32'h00);
        tick();
        check("e_blocked_valid", 32'(valid), 32'h0);
        en = 1'b1; tick();
        check("e_no_late_edge", 32'(pend), 32'h00);
        tick();
        check("e_no_late_valid", 32'(valid), 32'h0);
        d = 8'h00; tick();
        d = 8'h04; tick();
        check("e_new_pend", 32'(pend), 32'h04);
        tick();
        check("e_code2", 32'(code), 32'h2);
        check("e_valid2", 32'(valid), 32'h1);
        ready = 1'b1; tick();
        check("e_done", 32'(valid), 32'h0);
        ready = 1'b0;

        // ---- line held high across reset release ----
        rst = 1'b1; d = 8'h80; tick(); tick();
        check("h_rst_pend", 32'(pend), 32'h00);
        check("h_rst_valid", 32'(valid), 32'h0);
        rst = 1'b0; tick();
        check("h_pend", 32'(pend), 32'h80);
        tick();
        check("h_code7", 32'(code), 32'h7);
        check("h_valid7", 32'(valid), 32'h1);
        ready = 1'b1; tick();
        check("h_off", 32'(valid), 32'h0);
        tick(); tick();
        check("h_no_repeat_valid", 32'(valid), 32'h0);
        check("h_no_repeat_pend", 32'(pend), 32'h00);
        ready = 1'b0; d = 8'h00; tick();

        // ---- reset mid-handshake ----
        d = 8'h08; tick();
        d = 8'h00; tick();
        check("r_code3", 32'(code), 32'h3);
        d = 8'h0C; tick();
        check("r_pend", 32'(pend), 32'h0C);
        check("r_valid", 32'(valid), 32'h1);
        check("r_cnt", 32'(pend_cnt), 32'h2);
        d = 8'h00; rst = 1'b1; tick();
        rst = 1'b0;
        check("r_valid0", 32'(valid), 32'h0);
        check("r_pend0", 32'(pend), 32'h00);
        check("r_cnt0", 32'(pend_cnt), 32'h0);
        check("r_ovf0", 32'(overflow), 32'h0);
        check("r_code0", 32'(code), 32'h0);
        tick(); tick();
        check("r_quiet", 32'(valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
